// File: rtl/rdcntrl_gen_if.sv
// Bundle for the rdcntrl_gen readout controller: trigger-match inputs, SCA
// readout handshake and L1A-number FIFO port. The master drives the inputs.
interface rdcntrl_gen_if #(
    parameter int BLK_W  = 4,
    parameter int L1P_W  = 8,
    parameter int L1AN_W = 6
);
    logic              PBEND;
    logic              MATCH;
    logic              NO_MATCH;
    logic              L1A;
    logic              L1A_PHASE;
    logic [2:0]        WIN;
    logic [BLK_W-1:0]  BLKIN;
    logic [L1P_W-1:0]  L1PIN;
    logic              TRGDONE;
    logic              POPL1AN;
    logic              DAV;
    logic [BLK_W-1:0]  BLKOUT;
    logic [L1P_W-1:0]  L1POUT;
    logic              SCND_BLK;
    logic              NOL1A_MATCH;
    logic              DFULL;
    logic              DEMPTY;
    logic              OVF;
    logic [L1AN_W-1:0] L1ANUM;
    logic              L1A_PHASE_OUT;
    logic              L1EMPTY;
    logic              L1FULL;
    logic              PERR;

    modport master (
        output PBEND, MATCH, NO_MATCH, L1A, L1A_PHASE, WIN, BLKIN, L1PIN, TRGDONE, POPL1AN,
        input  DAV, BLKOUT, L1POUT, SCND_BLK, NOL1A_MATCH, DFULL, DEMPTY, OVF,
               L1ANUM, L1A_PHASE_OUT, L1EMPTY, L1FULL, PERR
    );

    modport slave (
        input  PBEND, MATCH, NO_MATCH, L1A, L1A_PHASE, WIN, BLKIN, L1PIN, TRGDONE, POPL1AN,
        output DAV, BLKOUT, L1POUT, SCND_BLK, NOL1A_MATCH, DFULL, DEMPTY, OVF,
               L1ANUM, L1A_PHASE_OUT, L1EMPTY, L1FULL, PERR
    );
endinterface

// File: rtl/rdcntrl_gen.sv
// CFEB readout controller: match history, descriptor FIFO with DAV/TRGDONE
// handshake, and L1A-number FIFO. Define RDCNTRL_PARITY_EN for descriptor parity.
module rdcntrl_gen #(
    parameter int BLK_W   = 4,
    parameter int L1P_W   = 8,
    parameter int L1AN_W  = 6,
    parameter int QDEPTH  = 4,
    parameter int MAX_WIN = 4
) (
    input logic          CLK,
    input logic          RST_N,
    rdcntrl_gen_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
`ifdef RDCNTRL_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int DW = BLK_W + L1P_W + 1 + PW;
    localparam logic [2:0]    WIN_MAX = 3'(MAX_WIN);
    localparam logic [CW-1:0] DEPTH   = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, PRES, POPS} state_e;

    state_e              state_q, state_d;
    logic [MAX_WIN:0]    f_q, f_d, l_q, l_d;
    logic [DW-1:0]       dmem_q [QDEPTH];
    logic [L1AN_W:0]     lmem_q [QDEPTH];
    logic [AW-1:0]       d_wr_q, d_wr_d, d_rd_q, d_rd_d;
    logic [AW-1:0]       l_wr_q, l_wr_d, l_rd_q, l_rd_d;
    logic [CW-1:0]       d_cnt_q, d_cnt_d, l_cnt_q, l_cnt_d;
    logic [L1AN_W-1:0]   l1a_cnt_q, l1a_cnt_d;
    logic                ovf_q, ovf_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [L1P_W-1:0]    l1p_q, l1p_d;
    logic                scnd_q, scnd_d;
`ifdef RDCNTRL_PARITY_EN
    logic                perr_q, perr_d;
`endif

    logic [2:0]          win_eff;
    logic                yes, lno;
    logic [DW-1:0]       d_entry, d_head;
    logic                d_full, d_empty, d_push, d_pop, d_wr_en;
    logic                l_full, l_empty, l_pop, l_wr_en;
    logic                load;

    // Effective window clamps WIN into 1..MAX_WIN before selecting history taps.
    always_comb begin
        win_eff = bus.WIN;
        if (bus.WIN == 3'd0)        win_eff = 3'd1;
        else if (bus.WIN > WIN_MAX) win_eff = WIN_MAX;
        yes = 1'b0;
        lno = 1'b0;
        for (int k = 1; k <= MAX_WIN; k++) begin
            if (k <= int'(win_eff)) begin
                yes = yes | f_q[k];
                lno = lno | l_q[k];
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        f_d = f_q;
        l_d = l_q;
        if (bus.PBEND) begin
            f_d[MAX_WIN:1] = f_q[MAX_WIN-1:0];
            l_d[MAX_WIN:1] = l_q[MAX_WIN-1:0];
        end
        f_d[0] = bus.MATCH    | (f_q[0] & ~bus.PBEND);
        l_d[0] = bus.NO_MATCH | (l_q[0] & ~bus.PBEND);
    end

`ifdef RDCNTRL_PARITY_EN
    assign d_entry = {bus.BLKIN, bus.L1PIN, f_q[1], ^{bus.BLKIN, bus.L1PIN, f_q[1]}};
`else
    assign d_entry = {bus.BLKIN, bus.L1PIN, f_q[1]};
`endif
    assign d_head  = dmem_q[d_rd_q];
    assign d_full  = (d_cnt_q == DEPTH);
    assign d_empty = (d_cnt_q == '0);
    assign d_push  = bus.PBEND & f_q[0];
    assign d_pop   = (state_q == POPS) & ~d_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign d_wr_en = d_push & (~d_full | d_pop);

    assign l_full  = (l_cnt_q == DEPTH);
    assign l_empty = (l_cnt_q == '0);
    assign l_pop   = bus.POPL1AN & ~l_empty;
    assign l_wr_en = bus.L1A & (~l_full | l_pop);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (!d_empty) begin
                state_d = PRES;
                load    = 1'b1;
            end
            PRES: if (bus.TRGDONE) state_d = POPS;
            POPS: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        d_wr_d    = d_wr_en ? d_wr_q + 1'b1 : d_wr_q;
        d_rd_d    = d_pop   ? d_rd_q + 1'b1 : d_rd_q;
        l_wr_d    = l_wr_en ? l_wr_q + 1'b1 : l_wr_q;
        l_rd_d    = l_pop   ? l_rd_q + 1'b1 : l_rd_q;
        d_cnt_d   = d_cnt_q;
        l_cnt_d   = l_cnt_q;
        case ({d_wr_en, d_pop})
            2'b10:   d_cnt_d = d_cnt_q + 1'b1;
            2'b01:   d_cnt_d = d_cnt_q - 1'b1;
            default: d_cnt_d = d_cnt_q;
        endcase
        case ({l_wr_en, l_pop})
            2'b10:   l_cnt_d = l_cnt_q + 1'b1;
            2'b01:   l_cnt_d = l_cnt_q - 1'b1;
            default: l_cnt_d = l_cnt_q;
        endcase
        l1a_cnt_d = bus.L1A ? l1a_cnt_q + 1'b1 : l1a_cnt_q;
        ovf_d     = ovf_q | (d_push & ~d_wr_en) | (bus.L1A & ~l_wr_en);
        blk_d     = load ? d_head[DW-1 -: BLK_W]       : blk_q;
        l1p_d     = load ? d_head[DW-1-BLK_W -: L1P_W] : l1p_q;
        scnd_d    = load ? d_head[PW]                   : scnd_q;
`ifdef RDCNTRL_PARITY_EN
        perr_d    = load & (^d_head);
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            f_q       <= '0;
            l_q       <= '0;
            d_wr_q    <= '0;
            d_rd_q    <= '0;
            d_cnt_q   <= '0;
            l_wr_q    <= '0;
            l_rd_q    <= '0;
            l_cnt_q   <= '0;
            l1a_cnt_q <= '0;
            ovf_q     <= 1'b0;
            blk_q     <= '0;
            l1p_q     <= '0;
            scnd_q    <= 1'b0;
`ifdef RDCNTRL_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            l_q       <= l_d;
            d_wr_q    <= d_wr_d;
            d_rd_q    <= d_rd_d;
            d_cnt_q   <= d_cnt_d;
            l_wr_q    <= l_wr_d;
            l_rd_q    <= l_rd_d;
            l_cnt_q   <= l_cnt_d;
            l1a_cnt_q <= l1a_cnt_d;
            ovf_q     <= ovf_d;
            blk_q     <= blk_d;
            l1p_q     <= l1p_d;
            scnd_q    <= scnd_d;
`ifdef RDCNTRL_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // NOTE: FIFO storage is not reset; the counts gate every read, so stale words are never used.
    always_ff @(posedge CLK) begin
        if (d_wr_en) dmem_q[d_wr_q] <= d_entry;
        if (l_wr_en) lmem_q[l_wr_q] <= {l1a_cnt_q, bus.L1A_PHASE};
    end

    assign bus.DAV           = (state_q == PRES);
    assign bus.BLKOUT        = blk_q;
    assign bus.L1POUT        = l1p_q;
    assign bus.SCND_BLK      = scnd_q;
    assign bus.NOL1A_MATCH   = lno & ~yes;
    assign bus.DFULL         = d_full;
    assign bus.DEMPTY        = d_empty;
    assign bus.OVF           = ovf_q;
    assign bus.L1ANUM        = lmem_q[l_rd_q][L1AN_W:1];
    assign bus.L1A_PHASE_OUT = lmem_q[l_rd_q][0];
    assign bus.L1EMPTY       = l_empty;
    assign bus.L1FULL        = l_full;
`ifdef RDCNTRL_PARITY_EN
    assign bus.PERR          = perr_q;
`else
    assign bus.PERR          = 1'b0;
`endif
endmodule

// File: doc/rdcntrl_gen.md
Name: rdcntrl_gen

Overview:
Parametrised successor to the fixed CFEB readout controller. Tracks LCT/L1A match history per pipeline block over a programmable window and queues readout descriptors (block address, L1A position map, second-block flag). Presents each descriptor to the SCA readout through a DAV/TRGDONE handshake and queues L1A numbers with phase for the data formatter. Sits between the trigger-match logic and the SCA readout state machine.

Parameters:
BLK_W, 4, pipeline block address width
L1P_W, 8, L1A position map width per descriptor
L1AN_W, 6, L1A counter / L1A number width
QDEPTH, 4, entries in each FIFO (descriptor and L1A number); power of 2, minimum 2
MAX_WIN, 4, maximum match window in pipeline blocks, minimum 1

Ports:
CLK  in  1  system clock
RST_N  in  1  reset; synchronous, active-low
PBEND  in  1  pipeline-block-end strobe
MATCH  in  1  LCT-L1A match inside the current block
NO_MATCH  in  1  L1A with no LCT inside the current block
L1A  in  1  L1A strobe
L1A_PHASE  in  1  phase of the 50 MHz enable at L1A
WIN  in  3  match window in blocks; 0 acts as 1, values above MAX_WIN act as MAX_WIN
BLKIN  in  BLK_W  block address of the ending block
L1PIN  in  L1P_W  L1A position map of the ending block
TRGDONE  in  1  readout of the presented descriptor complete
POPL1AN  in  1  pop the L1A number FIFO
DAV  out  1  descriptor valid on the outputs
BLKOUT  out  BLK_W  presented block address
L1POUT  out  L1P_W  presented position map
SCND_BLK  out  1  presented block is the second of a matched pair
NOL1A_MATCH  out  1  window contains NO_MATCH and no MATCH
DFULL  out  1  descriptor FIFO full
DEMPTY  out  1  descriptor FIFO empty
OVF  out  1  sticky overflow of either FIFO
L1ANUM  out  L1AN_W  head L1A number (first-word fall-through)
L1A_PHASE_OUT  out  1  head phase
L1EMPTY  out  1  L1A FIFO empty
L1FULL  out  1  L1A FIFO full

Behaviour:
- Reset, sampled on CLK while RST_N=0: flush both FIFOs, clear history, L1A counter=0, FSM=IDLE. Resulting outputs: DAV=0, BLKOUT/L1POUT/SCND_BLK=0, OVF=0, DEMPTY=L1EMPTY=1, DFULL=L1FULL=0, NOL1A_MATCH=0. Reset mid-handshake drops the presented descriptor.
- History: f[1..MAX_WIN+1] for MATCH, l[1..MAX_WIN+1] for NO_MATCH. Each cycle, f1 <= MATCH | (f1 & !PBEND). On PBEND, f[k+1] <= f[k]. l follows the same rules. A MATCH coinciding with PBEND belongs to the new block.
- yes = OR f[2..W+1] and lno = OR l[2..W+1], where W is the effective window. NOL1A_MATCH = lno & !yes, combinational from registers.
- Descriptor push: on PBEND & f1, entry = {BLKIN, L1PIN, SCND=f2}.
  - Push while full is dropped and OVF is set.
  - Push and pop in the same cycle while full: both take effect.
  - Pop while empty is ignored.
- Readout FSM, three states:
  - IDLE: when !DEMPTY, go to PRES and register the head entry onto the outputs.
  - PRES: DAV=1, outputs held stable. On TRGDONE go to POPS.
  - POPS: pop the head, DAV=0, go to IDLE.
  - TRGDONE outside PRES is ignored.
  - Latency: push in cycle t gives DEMPTY=0 at t+1 and DAV=1 at t+2. Back-to-back descriptors are separated by at least 1 DAV-low cycle.
- L1A counter: on L1A, push {count, L1A_PHASE} into the L1A FIFO, then increment count. Count wraps from 2^L1AN_W-1 to 0. The first L1A after reset carries number 0. If the FIFO is full the push is dropped, OVF is set, and the counter still increments.
- OVF clears only on reset.

Optional Feature:
RDCNTRL_PARITY_EN:
- Defined: each descriptor entry stores an even-parity bit over {BLKIN, L1PIN, SCND}, checked at the IDLE->PRES load. Output PERR (1 bit, added port) pulses for 1 cycle in the first PRES cycle when a mismatch is found. Reset value 0.
- Undefined: no parity storage. PERR is present and tied 0.

Test Plan:
1. MATCH in block 3, PBEND with BLKIN=3, L1PIN=8'h10 -> DAV=1 exactly 2 cycles after PBEND, BLKOUT=3, L1POUT=8'h10, SCND_BLK=0; TRGDONE -> DAV=0 the next cycle, DEMPTY=1.
2. MATCH in two consecutive blocks (5, 6) -> two descriptors, second one has SCND_BLK=1.
3. WIN=2, NO_MATCH in one block, then 2 PBENDs -> NOL1A_MATCH=1 for one window. Repeat with WIN=4 -> asserted for 4 blocks. Repeat with WIN=7 -> behaves as 4.
4. QDEPTH+1 matched blocks with no TRGDONE -> DFULL=1, OVF=1, last entry lost. Drain -> exactly QDEPTH descriptors in order.
5. 2^L1AN_W+1 L1As with interleaved POPL1AN -> L1ANUM sequence 0..63 then 0; L1A_PHASE_OUT follows the applied phase.
6. RST_N=0 for 1 cycle while DAV=1 -> DAV=0, DEMPTY=1, OVF=0 the next cycle. Subsequent TRGDONE has no effect.
